// File: rtl/fir_xifu_ex_pkg.sv
// Shared types and constants for the FIR XIF coprocessor execute stage.
package fir_xifu_ex_pkg;

  localparam int unsigned DOTP_LANE_W = 16;
  localparam int unsigned DOTP_LANES  = 2;
  localparam int unsigned REG_AW      = 5;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    XFIRLW   = 2'd1,
    XFIRSW   = 2'd2,
    XFIRDOTP = 2'd3
  } instr_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    WB       = 2'd3
  } ex_state_e;

  typedef struct packed {
    instr_e              instr;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
    logic [31:0]         base;
    logic [31:0]         offset;
  } id_ex_t;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [31:0]       wdata;
  } ex_wb_t;

  // Register fields are 5 bits wide but the internal file may be smaller.
  function automatic logic [REG_AW-1:0] reg_idx(input logic [REG_AW-1:0] r,
                                                input int unsigned nregs);
    return REG_AW'(32'(r) % nregs);
  endfunction

endpackage

// File: rtl/fir_xifu_ex_if.sv
// XIF memory request/result channel between the execute stage and the core.
interface fir_xifu_ex_if #(
  parameter int unsigned ID_WIDTH = 4
) ();

  logic                valid;
  logic                ready;
  logic [31:0]         addr;
  logic                we;
  logic [31:0]         wdata;
  logic [ID_WIDTH-1:0] id;
  logic                result_valid;
  logic [31:0]         rdata;

  modport master (
    output valid, addr, we, wdata, id,
    input  ready, result_valid, rdata
  );

  modport slave (
    input  valid, addr, we, wdata, id,
    output ready, result_valid, rdata
  );

endinterface

// File: rtl/fir_xifu_dotp.sv
// Combinational packed 2x16-bit signed multiply-accumulate: c + a.lo*b.lo + a.hi*b.hi.
module fir_xifu_dotp
  import fir_xifu_ex_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] res_o
);

  logic signed [2*DOTP_LANE_W-1:0] lane_prod [DOTP_LANES];

  for (genvar gi = 0; gi < DOTP_LANES; gi++) begin : g_lane
    logic signed [DOTP_LANE_W-1:0] a_lane;
    logic signed [DOTP_LANE_W-1:0] b_lane;
    assign a_lane        = a_i[gi*DOTP_LANE_W +: DOTP_LANE_W];
    assign b_lane        = b_i[gi*DOTP_LANE_W +: DOTP_LANE_W];
    assign lane_prod[gi] = a_lane * b_lane;
  end

  // Plain 32-bit wrap; no saturation on the accumulate.
  assign res_o = c_i + lane_prod[0] + lane_prod[1];

endmodule

// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR XIF coprocessor: load/store address generation and
// memory handshake, packed dot-product MAC, and register-file writeback.
module fir_xifu_ex
  import fir_xifu_ex_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned NREGS    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                valid_i,
  input  instr_e              instr_i,
  input  logic [31:0]         base_i,
  input  logic [31:0]         offset_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [4:0]          rd_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                ready_o,
  output logic [4:0]          rf_raddr_a_o,
  output logic [4:0]          rf_raddr_b_o,
  output logic [4:0]          rf_raddr_c_o,
  input  logic [31:0]         rf_rdata_a_i,
  input  logic [31:0]         rf_rdata_b_i,
  input  logic [31:0]         rf_rdata_c_i,
  output logic                rf_we_o,
  output logic [4:0]          rf_waddr_o,
  output logic [31:0]         rf_wdata_o,
  fir_xifu_ex_if.master       mem,
  output logic                done_o,
  output logic [ID_WIDTH-1:0] done_id_o
);

  ex_state_e           state_reg, state_next;
  logic                kill_reg, kill_next;
  instr_e              instr_reg;
  logic [ID_WIDTH-1:0] id_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         sdata_reg;
  ex_wb_t              wb_reg;

  id_ex_t      id_ex;
  logic        accept;
  logic        load_capture;
  logic [31:0] dotp_res;

  assign id_ex = '{instr: instr_i, rs1: rs1_i, rs2: rs2_i, rd: rd_i,
                   base: base_i, offset: offset_i};

  assign rf_raddr_a_o = reg_idx(id_ex.rs1, NREGS);
  assign rf_raddr_b_o = reg_idx(id_ex.rs2, NREGS);
  assign rf_raddr_c_o = reg_idx(id_ex.rd, NREGS);

  fir_xifu_dotp u_dotp (
    .a_i   (rf_rdata_a_i),
    .b_i   (rf_rdata_b_i),
    .c_i   (rf_rdata_c_i),
    .res_o (dotp_res)
  );

  assign ready_o = (state_reg == IDLE);
  // A flush presented alongside a new instruction drops that instruction.
  assign accept  = valid_i && ready_o && !clear_i && (id_ex.instr != INVALID);

  assign load_capture = (state_reg == MEM_WAIT) && mem.result_valid && !kill_reg
                        && !clear_i && (instr_reg == XFIRLW);

  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (id_ex.instr == XFIRDOTP) ? WB : MEM_REQ;
        end
      end
      MEM_REQ: begin
        // Once the request is accepted the result must still be drained.
        if (mem.ready) begin
          state_next = MEM_WAIT;
          kill_next  = clear_i;
        end else if (clear_i) begin
          state_next = IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem.result_valid) begin
          state_next = (kill_reg || clear_i) ? IDLE : WB;
        end else if (clear_i) begin
          kill_next = 1'b1;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next == IDLE) begin
      kill_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      kill_reg  <= 1'b0;
      instr_reg <= INVALID;
      id_reg    <= '0;
      addr_reg  <= '0;
      sdata_reg <= '0;
      wb_reg    <= '0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
      if (accept) begin
        instr_reg    <= id_ex.instr;
        id_reg       <= id_i;
        addr_reg     <= id_ex.base + id_ex.offset;
        sdata_reg    <= rf_rdata_b_i;
        wb_reg.waddr <= reg_idx(id_ex.rd, NREGS);
        wb_reg.wdata <= dotp_res;
      end else if (load_capture) begin
        wb_reg.wdata <= mem.rdata;
      end
    end
  end

  assign mem.valid = (state_reg == MEM_REQ);
  assign mem.addr  = addr_reg;
  assign mem.we    = (instr_reg == XFIRSW);
  assign mem.wdata = sdata_reg;
  assign mem.id    = id_reg;

  assign rf_we_o    = (state_reg == WB) && !clear_i && (instr_reg != XFIRSW);
  assign rf_waddr_o = wb_reg.waddr;
  assign rf_wdata_o = wb_reg.wdata;
  assign done_o     = (state_reg == WB) && !clear_i;
  assign done_id_o  = id_reg;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Directed bench for fir_xifu_ex with an instruction-level model of expected
// writebacks, completions and memory requests checked every cycle.
module tb_fir_xifu_ex;
  import fir_xifu_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        valid_i = 1'b0;
  instr_e      instr_i = INVALID;
  logic [31:0] base_i = '0, offset_i = '0;
  logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic [3:0]  id_i = '0;
  logic        ready_o;
  logic [4:0]  rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o;
  logic [31:0] rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        done_o;
  logic [3:0]  done_id_o;

  fir_xifu_ex_if #(.ID_WIDTH(4)) mem_if ();

  fir_xifu_ex #(.ID_WIDTH(4), .NREGS(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .valid_i(valid_i),
    .instr_i(instr_i), .base_i(base_i), .offset_i(offset_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .id_i(id_i), .ready_o(ready_o),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_raddr_c_o(rf_raddr_c_o),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .mem(mem_if.master), .done_o(done_o), .done_id_o(done_id_o)
  );

  always #5 clk = ~clk;

  // External register file
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  assign rf_rdata_a_i = rf[rf_raddr_a_o];
  assign rf_rdata_b_i = rf[rf_raddr_b_o];
  assign rf_rdata_c_i = rf[rf_raddr_c_o];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end else if (rf_we_o) begin
      rf[rf_waddr_o] <= rf_wdata_o;
    end
  end

  // Model state and expectation queues
  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] id; } mreq_t;
  logic [31:0] model_rf [32];
  wr_t         exp_wr[$];
  logic [3:0]  exp_done[$];
  mreq_t       exp_mem[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_dotp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    longint s;
    s = longint'($signed(c))
      + longint'($signed(a[15:0])) * longint'($signed(b[15:0]))
      + longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
    return s[31:0];
  endfunction

  task automatic model_push(input instr_e ins, input logic [31:0] base, input logic [31:0] off,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [3:0] id, input logic [31:0] ldata, input bit killed);
    logic [31:0] res;
    case (ins)
      XFIRDOTP: begin
        res = model_dotp(model_rf[r1], model_rf[r2], model_rf[rd]);
        exp_wr.push_back('{rd, res});
        exp_done.push_back(id);
        model_rf[rd] = res;
      end
      XFIRLW: begin
        exp_mem.push_back('{base + off, 1'b0, 32'h0, id});
        if (!killed) begin
          exp_wr.push_back('{rd, ldata});
          exp_done.push_back(id);
          model_rf[rd] = ldata;
        end
      end
      XFIRSW: begin
        exp_mem.push_back('{base + off, 1'b1, model_rf[r2], id});
        if (!killed) exp_done.push_back(id);
      end
      default: ;
    endcase
  endtask

  // Per-cycle compare against the model queues
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we_o) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'(rf_we_o), 32'h0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(rf_waddr_o), 32'(e.addr));
          chk("wr_data", rf_wdata_o, e.data);
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) chk("done_unexpected", 32'(done_o), 32'h0);
        else chk("done_id", 32'(done_id_o), 32'(exp_done.pop_front()));
      end
      if (mem_if.valid) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", 32'(mem_if.valid), 32'h0);
        else begin
          mreq_t m;
          m = exp_mem[0];
          chk("mem_addr", mem_if.addr, m.addr);
          chk("mem_we", 32'(mem_if.we), 32'(m.we));
          chk("mem_id", 32'(mem_if.id), 32'(m.id));
          if (m.we) chk("mem_wdata", mem_if.wdata, m.wdata);
          if (mem_if.ready) void'(exp_mem.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic issue(input instr_e ins, input logic [31:0] base, input logic [31:0] off,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [3:0] id, input logic [31:0] ldata, input bit killed);
    int w;
    w = 0;
    while (!ready_o && w < 20) begin tick(); w++; end
    chk("issue_ready", 32'(ready_o), 32'h1);
    model_push(ins, base, off, r1, r2, rd, id, ldata, killed);
    valid_i = 1'b1; instr_i = ins; base_i = base; offset_i = off;
    rs1_i = r1; rs2_i = r2; rd_i = rd; id_i = id;
    tick();
    valid_i = 1'b0; instr_i = INVALID;
  endtask

  initial begin
    int mism;
    mem_if.ready = 1'b0; mem_if.result_valid = 1'b0; mem_if.rdata = '0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(ready_o), 32'h1);
    chk("rst_mem_valid", 32'(mem_if.valid), 32'h0);
    chk("rst_rf_we", 32'(rf_we_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_mem_addr", mem_if.addr, 32'h0);
    chk("rst_rf_wdata", rf_wdata_o, 32'h0);
    $display("reset state checked");

    // DOTP: 10 + (-2*5) + (3*2) = 6
    preload(5'd1, 32'h0003_FFFE);
    preload(5'd2, 32'h0002_0005);
    preload(5'd3, 32'd10);
    issue(XFIRDOTP, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'd5, 32'h0, 1'b0);
    chk("dotp_we", 32'(rf_we_o), 32'h1);
    chk("dotp_waddr", 32'(rf_waddr_o), 32'd3);
    chk("dotp_wdata", rf_wdata_o, 32'd6);
    chk("dotp_done_id", 32'(done_id_o), 32'd5);
    tick();
    $display("dotp rd=3 wdata=%h", rf[3]);

    // LW with two stalled request cycles: 0x1000 - 4 = 0x0FFC
    issue(XFIRLW, 32'h1000, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd7, 4'd3, 32'hDEAD_BEEF, 1'b0);
    for (int s = 0; s < 2; s++) begin
      chk("lw_valid_held", 32'(mem_if.valid), 32'h1);
      chk("lw_addr_held", mem_if.addr, 32'h0000_0FFC);
      tick();
    end
    mem_if.ready = 1'b1;
    chk("lw_we", 32'(mem_if.we), 32'h0);
    tick();
    mem_if.ready = 1'b0;
    mem_if.result_valid = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
    tick();
    mem_if.result_valid = 1'b0;
    chk("lw_rf_we", 32'(rf_we_o), 32'h1);
    chk("lw_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    chk("lw_done", 32'(done_o), 32'h1);
    tick();
    $display("lw addr=0ffc rd=7 data=%h", rf[7]);

    // SW with address wraparound: 0xFFFFFFFC + 8 = 0x4
    preload(5'd5, 32'h1234_5678);
    issue(XFIRSW, 32'hFFFF_FFFC, 32'd8, 5'd0, 5'd5, 5'd0, 4'd9, 32'h0, 1'b0);
    chk("sw_addr", mem_if.addr, 32'h0000_0004);
    chk("sw_wdata", mem_if.wdata, 32'h1234_5678);
    mem_if.ready = 1'b1;
    tick();
    mem_if.ready = 1'b0;
    mem_if.result_valid = 1'b1;
    tick();
    mem_if.result_valid = 1'b0;
    chk("sw_no_we", 32'(rf_we_o), 32'h0);
    chk("sw_done", 32'(done_o), 32'h1);
    chk("sw_done_id", 32'(done_id_o), 32'd9);
    tick();
    $display("sw addr=00000004 wdata=12345678");

    // Back-to-back accumulating DOTP into r3: 6 -> 2 -> -2
    model_push(XFIRDOTP, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'd1, 32'h0, 1'b0);
    model_push(XFIRDOTP, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'd2, 32'h0, 1'b0);
    valid_i = 1'b1; instr_i = XFIRDOTP; rs1_i = 5'd1; rs2_i = 5'd2; rd_i = 5'd3; id_i = 4'd1;
    chk("b2b_ready0", 32'(ready_o), 32'h1);
    tick();
    chk("b2b_ready1", 32'(ready_o), 32'h0);
    chk("b2b_wdata1", rf_wdata_o, 32'd2);
    id_i = 4'd2;
    tick();
    chk("b2b_ready2", 32'(ready_o), 32'h1);
    tick();
    chk("b2b_ready3", 32'(ready_o), 32'h0);
    chk("b2b_wdata2", rf_wdata_o, 32'hFFFF_FFFE);
    valid_i = 1'b0; instr_i = INVALID;
    tick();
    $display("b2b dotp r3=%h", rf[3]);

    // clear_i in MEM_WAIT: result discarded, no write, no done
    issue(XFIRLW, 32'h2000, 32'h0, 5'd0, 5'd0, 5'd9, 4'd2, 32'h0, 1'b1);
    mem_if.ready = 1'b1;
    tick();
    mem_if.ready = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    mem_if.result_valid = 1'b1; mem_if.rdata = 32'hAAAA_5555;
    chk("kill_ready_wait", 32'(ready_o), 32'h0);
    tick();
    mem_if.result_valid = 1'b0;
    chk("kill_ready_after", 32'(ready_o), 32'h1);
    chk("kill_no_we", 32'(rf_we_o), 32'h0);
    chk("kill_no_done", 32'(done_o), 32'h0);
    tick();
    $display("clear in MEM_WAIT r9=%h", rf[9]);

    // clear_i in MEM_REQ without handshake: request withdrawn
    issue(XFIRLW, 32'h3000, 32'h10, 5'd0, 5'd0, 5'd10, 4'd4, 32'h0, 1'b1);
    clear_i = 1'b1;
    chk("clrreq_valid", 32'(mem_if.valid), 32'h1);
    tick();
    clear_i = 1'b0;
    chk("clrreq_dropped", 32'(mem_if.valid), 32'h0);
    chk("clrreq_ready", 32'(ready_o), 32'h1);
    exp_mem.delete();
    tick();
    $display("clear in MEM_REQ");

    // rst_i in MEM_REQ
    issue(XFIRSW, 32'h100, 32'h0, 5'd0, 5'd5, 5'd0, 4'd6, 32'h0, 1'b1);
    chk("rstreq_valid", 32'(mem_if.valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_mem.delete();
    chk("rstreq_mem_valid", 32'(mem_if.valid), 32'h0);
    chk("rstreq_ready", 32'(ready_o), 32'h1);
    chk("rstreq_mem_addr", mem_if.addr, 32'h0);
    chk("rstreq_mem_we", 32'(mem_if.we), 32'h0);
    chk("rstreq_mem_wdata", mem_if.wdata, 32'h0);
    chk("rstreq_done_id", 32'(done_id_o), 32'h0);
    chk("rstreq_rf_waddr", 32'(rf_waddr_o), 32'h0);
    tick();
    $display("rst in MEM_REQ");

    // Post-reset DOTP on cleared file still behaves
    preload(5'd4, 32'hFFFF_7FFF);
    issue(XFIRDOTP, 32'h0, 32'h0, 5'd4, 5'd4, 5'd4, 4'd7, 32'h0, 1'b0);
    tick();
    $display("dotp r4=%h", rf[4]);

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'h0);
    mism = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== model_rf[i]) mism++;
    chk("rf_final", 32'(mism), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
